// File: rtl/rand_pkg.sv
// Shared types and default sizing for the random-bit word packer.
package rand_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    FAULT   = 1'b1
  } rand_state_e;

  localparam int DEF_WORD_W     = 32;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_RCT_LIMIT  = 16;

endpackage

// File: rtl/rand_word_fifo.sv
// Show-ahead synchronous FIFO for completed words; a push while full is
// accepted only when a pop happens in the same cycle.
module rand_word_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // When full, the slot being written is the head being popped this cycle.
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_q];
  assign count_o = count_q;

endmodule

// File: rtl/rand_word_pack.sv
// Packs raw random bits LSB-first into words and buffers them in a FIFO.
// Define RAND_HEALTH_EN to build the repetition-count health test and FAULT state.
module rand_word_pack
  import rand_pkg::*;
#(
  parameter int WORD_W     = DEF_WORD_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int RCT_LIMIT  = DEF_RCT_LIMIT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_bit,
  input  logic                          in_bit_valid,
  output logic [WORD_W-1:0]             out_word,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          overflow,
  output logic                          health_fail,
  output logic [$clog2(FIFO_DEPTH):0]   fill
);

  localparam int CW = $clog2(WORD_W);

  logic [CW-1:0]     bcnt_q;
  logic [WORD_W-1:0] shreg_q, word_d;
  logic              accept, last_bit, trip, push;
  logic              overflow_q;
  logic              fifo_full, fifo_empty;

`ifdef RAND_HEALTH_EN
  rand_state_e state_q;
  logic [7:0]  run_q, run_d;
  logic        last_q, health_q;

  assign accept = in_bit_valid & (state_q == COLLECT);

  always_comb begin
    run_d = 8'd1;
    if (run_q != 8'd0 && in_bit == last_q)
      run_d = (run_q >= 8'(RCT_LIMIT)) ? run_q : run_q + 8'd1;
  end

  assign trip = accept & (run_d == 8'(RCT_LIMIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= COLLECT;
      run_q    <= '0;
      last_q   <= 1'b0;
      health_q <= 1'b0;
    end else begin
      case (state_q)
        COLLECT: if (accept) begin
          run_q  <= run_d;
          last_q <= in_bit;
          if (trip) begin
            state_q  <= FAULT;
            health_q <= 1'b1;
          end
        end
        FAULT: state_q <= FAULT;
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign health_fail = health_q;
`else
  assign accept      = in_bit_valid;
  assign trip        = 1'b0;
  assign health_fail = 1'b0;
`endif

  assign last_bit = (bcnt_q == CW'(WORD_W - 1));
  // The tripping bit never completes a word, even if it lands on the last slot.
  assign push     = accept & last_bit & ~trip;

  always_comb begin
    word_d         = shreg_q;
    word_d[bcnt_q] = in_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q     <= '0;
      shreg_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (trip) begin
        bcnt_q <= '0;
      end else if (accept) begin
        shreg_q <= word_d;
        bcnt_q  <= last_bit ? '0 : bcnt_q + 1'b1;
      end
      overflow_q <= push & fifo_full & ~(out_ready & ~fifo_empty);
    end
  end

  rand_word_fifo #(
    .W     (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (word_d),
    .pop_i   (out_ready),
    .rdata_o (out_word),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fill)
  );

  assign out_valid = ~fifo_empty;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_rand_word_pack.sv
// Directed bench: 8-bit packer for packing/FIFO/reset/health, 32-bit packer for the no-health build.
module tb_rand_word_pack;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_bit = 1'b0, in_bit_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] out_word;
  logic       out_valid, overflow, health_fail;
  logic [2:0] fill;

  logic        in_bit2 = 1'b0, in_bit_valid2 = 1'b0, out_ready2 = 1'b0;
  logic [31:0] out_word2;
  logic        out_valid2, overflow2, health_fail2;
  logic [2:0]  fill2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rand_word_pack #(.WORD_W(8), .FIFO_DEPTH(4), .RCT_LIMIT(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_bit_valid(in_bit_valid),
    .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow), .health_fail(health_fail), .fill(fill)
  );

  rand_word_pack #(.WORD_W(32), .FIFO_DEPTH(4), .RCT_LIMIT(16)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_bit(in_bit2), .in_bit_valid(in_bit_valid2),
    .out_word(out_word2), .out_valid(out_valid2), .out_ready(out_ready2),
    .overflow(overflow2), .health_fail(health_fail2), .fill(fill2)
  );

  task automatic do_reset();
    rst_n = 1'b0; in_bit_valid = 1'b0; out_ready = 1'b0;
    in_bit_valid2 = 1'b0; out_ready2 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send_bit(input logic b);
    in_bit = b; in_bit_valid = 1'b1;
    @(posedge clk); #1;
    in_bit_valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) send_bit(w[i]);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; #1;
    total++; if (out_valid !== 1'b0 || fill !== 3'd0 || out_word !== 8'h00 ||
                 overflow !== 1'b0 || health_fail !== 1'b0) begin
      bad++; $display("FAIL reset_state: valid=%b fill=%0d word=%h ovf=%b hf=%b want 0 0 00 0 0",
                      out_valid, fill, out_word, overflow, health_fail);
    end
    do_reset();
    out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    total++; if (out_valid !== 1'b0 || fill !== 3'd0) begin
      bad++; $display("FAIL empty_pop: valid=%b fill=%0d want 0 0", out_valid, fill);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_packing();
    logic [7:0] bits;
    bits = 8'h0D;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) send_bit(bits[i]);
    total++; if (out_valid !== 1'b0) begin
      bad++; $display("FAIL pack_early: valid=%b want 0", out_valid);
    end
    send_bit(bits[7]);
    total++; if (out_valid !== 1'b1 || out_word !== 8'h0D) begin
      bad++; $display("FAIL pack_word: valid=%b word=%h want 1 0d", out_valid, out_word);
    end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin
      bad++; $display("FAIL pack_popped: valid=%b want 0", out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    send_word(8'hA5); send_word(8'h3C); send_word(8'h96); send_word(8'h5A);
    total++; if (fill !== 3'd4 || overflow !== 1'b0) begin
      bad++; $display("FAIL ovf_full: fill=%0d ovf=%b want 4 0", fill, overflow);
    end
    send_word(8'hC3);
    total++; if (overflow !== 1'b1 || fill !== 3'd4 || out_word !== 8'hA5) begin
      bad++; $display("FAIL ovf_pulse: ovf=%b fill=%0d head=%h want 1 4 a5", overflow, fill, out_word);
    end
    @(posedge clk); #1;
    total++; if (overflow !== 1'b0 || out_word !== 8'hA5) begin
      bad++; $display("FAIL ovf_once: ovf=%b head=%h want 0 a5", overflow, out_word);
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp [4];
    logic [7:0] w5;
    exp[0] = 8'h3C; exp[1] = 8'h96; exp[2] = 8'h5A; exp[3] = 8'hC3;
    w5 = 8'hC3;
    do_reset();
    send_word(8'hA5); send_word(8'h3C); send_word(8'h96); send_word(8'h5A);
    for (int i = 0; i < 7; i++) send_bit(w5[i]);
    out_ready = 1'b1;
    send_bit(w5[7]);
    out_ready = 1'b0;
    total++; if (fill !== 3'd4 || overflow !== 1'b0 || out_word !== 8'h3C) begin
      bad++; $display("FAIL full_pushpop: fill=%0d ovf=%b head=%h want 4 0 3c", fill, overflow, out_word);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (out_valid !== 1'b1 || out_word !== exp[i]) begin
        bad++; $display("FAIL drain_%0d: valid=%b word=%h want 1 %h", i, out_valid, out_word, exp[i]);
      end
      @(posedge clk); #1;
    end
    total++; if (out_valid !== 1'b0 || fill !== 3'd0) begin
      bad++; $display("FAIL drain_empty: valid=%b fill=%0d want 0 0", out_valid, fill);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] w2;
    w2 = 8'h69;
    do_reset();
    send_word(8'h96);
    for (int i = 0; i < 7; i++) send_bit(w2[i]);
    out_ready = 1'b1;
    send_bit(w2[7]);
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b1 || out_word !== 8'h69 || fill !== 3'd1) begin
      bad++; $display("FAIL b2b_fill1: valid=%b word=%h fill=%0d want 1 69 1", out_valid, out_word, fill);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] w;
    w = 8'h18;
    do_reset();
    send_word(8'h3C); send_word(8'h96);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    rst_n = 1'b0; #1;
    total++; if (out_valid !== 1'b0 || fill !== 3'd0) begin
      bad++; $display("FAIL rst_mid: valid=%b fill=%0d want 0 0", out_valid, fill);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) send_bit(w[i]);
    total++; if (out_valid !== 1'b0) begin
      bad++; $display("FAIL rst_stale: valid=%b want 0", out_valid);
    end
    for (int i = 5; i < 8; i++) send_bit(w[i]);
    total++; if (out_valid !== 1'b1 || out_word !== 8'h18 || fill !== 3'd1) begin
      bad++; $display("FAIL rst_newword: valid=%b word=%h fill=%0d want 1 18 1", out_valid, out_word, fill);
    end
  endtask

`ifdef RAND_HEALTH_EN
  task automatic test_health();
    do_reset();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    for (int i = 0; i < 15; i++) send_bit(1'b1);
    total++; if (health_fail !== 1'b0) begin
      bad++; $display("FAIL hf_early: hf=%b want 0", health_fail);
    end
    send_bit(1'b1);
    total++; if (health_fail !== 1'b1 || fill !== 3'd2) begin
      bad++; $display("FAIL hf_trip: hf=%b fill=%0d want 1 2", health_fail, fill);
    end
    for (int i = 0; i < 8; i++) send_bit(i[0]);
    total++; if (fill !== 3'd2 || health_fail !== 1'b1) begin
      bad++; $display("FAIL hf_ignore: fill=%0d hf=%b want 2 1", fill, health_fail);
    end
    out_ready = 1'b1;
    total++; if (out_word !== 8'hF5) begin
      bad++; $display("FAIL hf_word1: word=%h want f5", out_word);
    end
    @(posedge clk); #1;
    total++; if (out_word !== 8'hFF || out_valid !== 1'b1) begin
      bad++; $display("FAIL hf_word2: word=%h valid=%b want ff 1", out_word, out_valid);
    end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin
      bad++; $display("FAIL hf_drained: valid=%b want 0", out_valid);
    end
    out_ready = 1'b0;
  endtask
`else
  task automatic test_no_health();
    do_reset();
    in_bit2 = 1'b1; in_bit_valid2 = 1'b1;
    repeat (100) @(posedge clk);
    #1 in_bit_valid2 = 1'b0;
    total++; if (health_fail2 !== 1'b0 || fill2 !== 3'd3 || out_word2 !== 32'hFFFFFFFF) begin
      bad++; $display("FAIL nohealth: hf=%b fill=%0d word=%h want 0 3 ffffffff",
                      health_fail2, fill2, out_word2);
    end
    out_ready2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++; if (out_valid2 !== 1'b1 || out_word2 !== 32'hFFFFFFFF) begin
        bad++; $display("FAIL nohealth_drain_%0d: valid=%b word=%h want 1 ffffffff", i, out_valid2, out_word2);
      end
      @(posedge clk); #1;
    end
    total++; if (out_valid2 !== 1'b0) begin
      bad++; $display("FAIL nohealth_empty: valid=%b want 0", out_valid2);
    end
    out_ready2 = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_packing();
    test_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_reset_mid();
`ifdef RAND_HEALTH_EN
    test_health();
`else
    test_no_health();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
